shift_pipe: RTL

Parametrised, registered multi-stage shift pipeline. It is the next generation of the team's single-flop d→q register and is built strictly on non-blocking stage updates. It adds configurable data width and depth, a per-cycle mode (hold / shift / parallel load / rotate), synchronous clear, tap visibility and a fill tracker. It serves as the generic delay-line and serialiser primitive for later practice blocks.

---
 rtl/shift_pipe.sv | 89 ++++++++
 1 files changed

// File: rtl/shift_pipe.sv
// shift_pipe: parametrised registered shift pipeline with hold/shift/load/rotate modes,
// synchronous clear, tap visibility and a saturating fill tracker.  Rev 1.0
`default_nettype none

module shift_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       d,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [CW-1:0]          fill,
  output logic                   full
);

  localparam logic [1:0]    MODE_HOLD   = 2'b00;
  localparam logic [1:0]    MODE_SHIFT  = 2'b01;
  localparam logic [1:0]    MODE_LOAD   = 2'b10;
  localparam logic [1:0]    MODE_ROTATE = 2'b11;
  localparam logic [CW-1:0] FILL_MAX    = CW'(DEPTH);
  localparam logic [CW-1:0] FILL_ALMOST = CW'(DEPTH - 1);

  // Stage i lives in stages[i*WIDTH +: WIDTH]; the whole vector is the flop bank.
  logic [WIDTH*DEPTH-1:0] stages;
  logic [WIDTH*DEPTH-1:0] shift_next;
  logic [WIDTH*DEPTH-1:0] rotate_next;

  generate
    if (DEPTH > 1) begin : g_multi_stage
      assign shift_next  = {stages[WIDTH*(DEPTH-1)-1:0], d};
      assign rotate_next = {stages[WIDTH*(DEPTH-1)-1:0], stages[WIDTH*DEPTH-1 -: WIDTH]};
    end else begin : g_single_stage
      // A one-stage rotate feeds the stage back onto itself.
      assign shift_next  = d;
      assign rotate_next = stages;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
      fill   <= '0;
      full   <= 1'b0;
    end else if (clr) begin
      stages <= '0;
      fill   <= '0;
      full   <= 1'b0;
    end else if (en) begin
      case (mode)
        MODE_SHIFT: begin
          stages <= shift_next;
          if (fill != FILL_MAX) begin
            fill <= fill + CW'(1);
          end
          if (fill == FILL_ALMOST) begin
            full <= 1'b1;
          end
        end
        MODE_LOAD: begin
          stages <= load_data;
          fill   <= FILL_MAX;
          full   <= 1'b1;
        end
        MODE_ROTATE: begin
          stages <= rotate_next;
        end
        MODE_HOLD: begin
          stages <= stages;
        end
        default: begin
          stages <= stages;
        end
      endcase
    end
  end

  assign q    = stages[WIDTH*(DEPTH-1) +: WIDTH];
  assign taps = stages;

endmodule

`default_nettype wire
